// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage.
// Decodes the immediate selected by in_imm_type (RV32/RV64 base formats plus
// optional RVC formats), forms the PC-relative target and presents both
// through a single output register with a valid/ready handshake and flush.
module imm_gen_pipe #(
   parameter int XLEN = 32,
   parameter bit C_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [3:0]      in_imm_type,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   localparam logic [3:0] TYPE_NO      = 4'd0;
   localparam logic [3:0] TYPE_I       = 4'd1;
   localparam logic [3:0] TYPE_B       = 4'd2;
   localparam logic [3:0] TYPE_S       = 4'd3;
   localparam logic [3:0] TYPE_U       = 4'd4;
   localparam logic [3:0] TYPE_J       = 4'd5;
   localparam logic [3:0] TYPE_I_SHIFT = 4'd6;
   localparam logic [3:0] TYPE_CSR     = 4'd7;
   localparam logic [3:0] TYPE_C_I     = 4'd8;
   localparam logic [3:0] TYPE_C_J     = 4'd9;
   localparam logic [3:0] TYPE_C_B     = 4'd10;

   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] target_s;
   logic            illegal_s;
   logic            accept_s;
   logic            valid_r;
   logic [XLEN-1:0] imm_r;
   logic [XLEN-1:0] target_r;
   logic            illegal_r;
   logic [1:0]      unused_instr_s;

   // The RVC opcode quadrant bits never contribute to an immediate.
   assign unused_instr_s = in_instr[1:0];

   // Immediate decode: every format is sign- or zero-extended straight to XLEN.
   always_comb begin
      imm_s     = '0;
      illegal_s = 1'b0;
      case (in_imm_type)
         TYPE_NO: begin
            imm_s = '0;
         end
         TYPE_I: begin
            imm_s = XLEN'($signed(in_instr[31:20]));
         end
         TYPE_B: begin
            imm_s = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
         end
         TYPE_S: begin
            imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         end
         TYPE_U: begin
            imm_s = XLEN'($signed({in_instr[31:12], 12'h000}));
         end
         TYPE_J: begin
            imm_s = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
         end
         TYPE_I_SHIFT: begin
            // RV32 only has 5-bit shift amounts; shamt[5] set is reserved there.
            if (XLEN == 64) begin
               imm_s = XLEN'(in_instr[25:20]);
            end else begin
               imm_s     = XLEN'(in_instr[24:20]);
               illegal_s = in_instr[25];
            end
         end
         TYPE_CSR: begin
            imm_s = XLEN'(in_instr[19:15]);
         end
         TYPE_C_I: begin
            if (C_EN) begin
               imm_s = XLEN'($signed({in_instr[12], in_instr[6:2]}));
            end else begin
               illegal_s = 1'b1;
            end
         end
         TYPE_C_J: begin
            if (C_EN) begin
               imm_s = XLEN'($signed({in_instr[12], in_instr[8], in_instr[10:9],
                                      in_instr[6], in_instr[7], in_instr[2],
                                      in_instr[11], in_instr[5:3], 1'b0}));
            end else begin
               illegal_s = 1'b1;
            end
         end
         TYPE_C_B: begin
            if (C_EN) begin
               imm_s = XLEN'($signed({in_instr[12], in_instr[6:5], in_instr[2],
                                      in_instr[11:10], in_instr[4:3], 1'b0}));
            end else begin
               illegal_s = 1'b1;
            end
         end
         default: begin
            imm_s     = '0;
            illegal_s = 1'b1;
         end
      endcase
   end

   assign target_s = in_pc + imm_s;

   // No skid buffer: upstream may only push when the output slot is free or draining.
   assign in_ready = !valid_r || out_ready;
   assign accept_s = in_valid && in_ready && !flush;

   // Output register: reset beats flush, flush beats acceptance; data moves only on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r   <= 1'b0;
         imm_r     <= '0;
         target_r  <= '0;
         illegal_r <= 1'b0;
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (accept_s) begin
         valid_r   <= 1'b1;
         imm_r     <= imm_s;
         target_r  <= target_s;
         illegal_r <= illegal_s;
      end else if (out_ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign out_valid   = valid_r;
   assign out_imm     = imm_r;
   assign out_target  = target_r;
   assign out_illegal = illegal_r;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage, replacing the purely combinational immediate decode. It adds RV64 sign extension, 6-bit shift amounts, optional RVC immediates, an illegal-type flag and a PC-relative target adder. The output is one pipeline register with a valid/ready handshake and a flush input. It sits between the instruction decoder (source of imm_type) and the execute stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
C_EN, 1, 1 = compressed immediate types decoded; 0 = they raise illegal.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_instr  in  32  instruction; RVC instructions occupy [15:0]
in_imm_type  in  4  immediate type code (encoding below)
in_pc  in  XLEN  PC of the instruction
flush  in  1  drop the held output beat
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts the beat
out_imm  out  XLEN  immediate
out_target  out  XLEN  in_pc + immediate, mod 2^XLEN
out_illegal  out  1  type code undefined or not supported

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_valid=0, out_imm=0, out_target=0, out_illegal=0.
- Type encoding and immediate formation. All sign extension is from instr[31] up to XLEN unless stated.
  - 0 NO: 0.
  - 1 I: instr[31:20], sign-extended.
  - 2 B: {instr[31],instr[7],instr[30:25],instr[11:8],0}, sign-extended.
  - 3 S: {instr[31:25],instr[11:7]}, sign-extended.
  - 4 U: {instr[31:12],12'b0}, sign-extended to XLEN (matters when XLEN=64).
  - 5 J: {instr[31],instr[19:12],instr[20],instr[30:21],0}, sign-extended.
  - 6 I_SHIFT: XLEN=64 gives zero-extended instr[25:20]. XLEN=32 gives zero-extended instr[24:20], and out_illegal=1 if instr[25]=1.
  - 7 CSR: zero-extended instr[19:15].
  - 8 C_I: {instr[12],instr[6:2]}, sign-extended from instr[12].
  - 9 C_J: offset[11|4|9:8|10|6|7|3:1|5] = instr[12:2], bit0=0, sign-extended from instr[12].
  - 10 C_B: offset[8|4:3] = instr[12:10]; offset[7:6|2:1|5] = instr[6:2]; bit0=0; sign-extended from instr[12].
  - 11–15: out_imm=0, out_illegal=1.
  - Types 8–10 with C_EN=0: out_imm=0, out_illegal=1.
- out_target is always in_pc + out_imm, for every type, wrapping at XLEN. Consumers decide whether to use it.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational with no skid buffer.
  - A beat is accepted when in_valid && in_ready. The outputs update on the next clk edge, so latency is 1 cycle.
  - Full throughput: one beat per cycle while out_ready=1.
  - While out_valid && !out_ready, out_imm, out_target and out_illegal hold stable and in_ready=0.
  - When out_valid && out_ready && !in_valid, the next cycle has out_valid=0; data registers keep their last value.
- Flush:
  - flush=1 sets out_valid=0 next cycle, regardless of out_ready.
  - Any beat presented in a flush cycle is discarded, even if in_ready=1.
  - flush takes priority over acceptance.
- rst has priority over flush and acceptance. Reset mid-stall drops the held beat; outputs return to reset values on the next edge.
- No state beyond the single output register. Data registers may update only on acceptance.

Test Plan:
- XLEN=32, I type, instr=0xFFF00093, pc=0x100 → one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_target=0x000000FF, out_illegal=0.
- B type, instr=0xFE000EE3, pc=0x100 → out_imm=0xFFFFFFFC, out_target=0x000000FC. Then send 4 back-to-back beats with out_ready=1 → 4 outputs on 4 consecutive cycles.
- XLEN=64: U type, instr=0x80000037 → out_imm=0xFFFFFFFF80000000. I_SHIFT, instr=0x03F09093 → out_imm=63. The same I_SHIFT instr with XLEN=32 → out_illegal=1.
- C_EN=1, C_J, instr=0x0000BFFD, pc=0x200 → out_imm=0xFFFFFFFE, out_target=0x1FE. The same instr with C_EN=0 → out_imm=0, out_illegal=1. Type 15 → out_illegal=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs unchanged throughout. Then out_ready=1 → the held beat completes and the next beat is accepted the same cycle.
- flush while a beat is held → out_valid=0 next cycle. Assert rst mid-stream → all outputs at reset values next cycle, and in_ready=1.
